// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Round-robin arbiter that shares the register file's single
//               write port (we3/a3/wd3) among NREQ writeback requesters. It
//               also keeps a pending-write scoreboard over the architectural
//               registers, which decode uses to detect read-after-write
//               hazards on its two source operands.
// Ports       : clk, rst_n        - clock (rising edge), async active-low reset
//               req_valid/ready   - per-requester handshake (ready one-hot)
//               req_addr/data     - packed per-requester destination and data
//               we3, a3, wd3      - registered regfile write port
//               sb_set/_addr      - issue marks a destination as pending
//               chk_a1, chk_a2    - source operands to check
//               hazard            - a nonzero source is still pending
//               byp1_hit, byp2_hit, byp_data - forwarding outputs, present
//                                   only when REGFILE_WB_ARB_BYPASS_EN is set
// Options     : `define REGFILE_WB_ARB_BYPASS_EN adds the forwarding outputs
//               and removes forwarded sources from the hazard.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic                 we3,
  output logic [AW-1:0]        a3,
  output logic [XLEN-1:0]      wd3,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_set_addr,
  input  logic [AW-1:0]        chk_a1,
  input  logic [AW-1:0]        chk_a2,
`ifdef REGFILE_WB_ARB_BYPASS_EN
  output logic                 byp1_hit,
  output logic                 byp2_hit,
  output logic [XLEN-1:0]      byp_data,
`endif
  output logic                 hazard
);

  localparam int c_PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int c_NREG = 1 << AW;

  logic [c_PW-1:0]   r_ptr;
  logic [c_NREG-1:0] r_pend;
  logic [c_NREG-1:0] w_pend_nxt;
  logic              w_any;
  logic [c_PW-1:0]   w_win;
  logic [c_PW-1:0]   w_ptr_nxt;
  logic [AW-1:0]     w_win_addr;
  logic [XLEN-1:0]   w_win_data;
  logic              w_pend1;
  logic              w_pend2;

  // Requester index that is 'off' positions after 'base', wrapping at NREQ
  // (NREQ need not be a power of two).
  function automatic logic [c_PW-1:0] f_wrap(input logic [c_PW-1:0] base,
                                             input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[c_PW-1:0];
  endfunction

  // Rotating-priority search: the first valid requester at or after r_ptr wins.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_any && req_valid[f_wrap(r_ptr, k)]) begin
        w_any = 1'b1;
        w_win = f_wrap(r_ptr, k);
      end
    end
  end

  // Grants are suppressed while reset is held so nothing appears accepted.
  always_comb begin
    req_ready = '0;
    if (rst_n && w_any) req_ready[w_win] = 1'b1;
  end

  assign w_ptr_nxt  = (w_win == c_PW'(NREQ - 1)) ? '0 : w_win + 1'b1;
  assign w_win_addr = req_addr[int'(w_win) * AW +: AW];
  assign w_win_data = req_data[int'(w_win) * XLEN +: XLEN];

  // Clear for the write currently on the port, then apply the issue set, so a
  // newer instruction claiming the same register keeps it pending.
  always_comb begin
    w_pend_nxt = r_pend;
    if (we3)    w_pend_nxt[a3]          = 1'b0;
    if (sb_set) w_pend_nxt[sb_set_addr] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_pend <= '0;
      we3    <= 1'b0;
      a3     <= '0;
      wd3    <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      // A write to x0 consumes its grant but never reaches the regfile.
      we3    <= w_any && (w_win_addr != '0);
      if (w_any) begin
        r_ptr <= w_ptr_nxt;
        a3    <= w_win_addr;
        wd3   <= w_win_data;
      end
    end
  end

  // The pending bit is cleared only at the regfile's write edge, so a source
  // whose write is on the port this cycle still reads as pending.
  assign w_pend1 = (chk_a1 != '0) && r_pend[chk_a1];
  assign w_pend2 = (chk_a2 != '0) && r_pend[chk_a2];

`ifdef REGFILE_WB_ARB_BYPASS_EN
  assign byp1_hit = we3 && (a3 == chk_a1) && (chk_a1 != '0);
  assign byp2_hit = we3 && (a3 == chk_a2) && (chk_a2 != '0);
  assign byp_data = wd3;
  assign hazard   = (w_pend1 && !byp1_hit) || (w_pend2 && !byp2_hit);
`else
  assign hazard   = w_pend1 || w_pend2;
`endif

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (we3/a3/wd3) among NREQ writeback requesters, e.g. ALU, load unit and CSR unit, using a registered round-robin arbiter.
- Also keeps a pending-write scoreboard over the 32 architectural registers. Decode uses it to detect read-after-write hazards on a1/a2 before issue.
- Sits between the execute/memory writeback sources and the regfile write port.

Parameters:
- NREQ, 3, number of writeback requesters (2..8).
- XLEN, 32, data width.
- AW, 5, register address width (2**AW registers; register 0 is hardwired zero).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester writeback valid.
- req_ready  output  NREQ  per-requester grant/accept, one-hot or zero.
- req_addr  input  NREQ*AW  packed destination addresses; requester i occupies [i*AW +: AW].
- req_data  input  NREQ*XLEN  packed write data; requester i occupies [i*XLEN +: XLEN].
- we3  output  1  regfile write enable, registered.
- a3  output  AW  regfile write address, registered.
- wd3  output  XLEN  regfile write data, registered.
- sb_set  input  1  issue marks a destination as pending.
- sb_set_addr  input  AW  destination being issued.
- chk_a1, chk_a2  input  AW  source addresses to check.
- hazard  output  1  combinational: chk_a1 or chk_a2 (nonzero) is pending.

Behaviour:
- Reset (async assert, sync release): we3=0, a3=0, wd3=0, scoreboard all clear, round-robin pointer=0.
  - req_ready is 0 while rst_n=0.
  - In the first cycle after reset, requester 0 has top priority.
- Handshake:
  - A requester asserts req_valid with addr and data, and holds all three stable until it sees req_ready=1.
  - Transfer occurs on the rising edge where valid and ready are both 1.
  - req_ready is combinational from req_valid and the pointer. Exactly one ready is high when any valid is high.
- Arbitration:
  - Search starts at index ptr and wraps modulo NREQ. The first valid requester wins.
  - On transfer, ptr <= winner+1, wrapping NREQ-1 -> 0.
  - With no valid request, ptr holds.
  - Full throughput: one transfer per cycle.
- Latency:
  - The transfer edge registers we3, a3 and wd3, so the write is presented in the cycle after acceptance.
  - The regfile commits the write at the following edge.
  - With no transfer, we3 <= 0 in the next cycle; a3/wd3 hold their last values.
- x0 writes:
  - A request with addr=0 is granted and consumes the grant, but we3 stays 0.
  - A request with addr=0 leaves the scoreboard unchanged.
- Scoreboard (1 bit per register; bit 0 is always 0):
  - Set: at the edge where sb_set=1 and sb_set_addr!=0.
  - Clear: at the edge where we3=1, for bit a3. This is the same edge on which the regfile writes.
  - Simultaneous set and clear of the same address: set wins, because a newer instruction now owns the register.
  - Set and clear of different addresses both take effect.
- hazard:
  - hazard = (chk_a1!=0 and pend[chk_a1]) or (chk_a2!=0 and pend[chk_a2]).
  - Because of the regfile's write-then-read ordering, a register whose clear edge is the current cycle still reads as pending. Decode stalls one more cycle.
- Reset mid-operation: outstanding grants and pending bits are discarded, and we3 drops immediately (async). Requesters must re-present their requests.

Optional Feature:
- Macro: REGFILE_WB_ARB_BYPASS_EN.
- When defined, the block adds outputs byp1_hit and byp2_hit (1 bit each) and byp_data (XLEN).
  - bypN_hit=1 when we3=1, a3 matches chk_aN and chk_aN!=0.
  - byp_data=wd3.
  - hazard excludes any source that hits the bypass, so decode proceeds using the forwarded value.
- When not defined, these ports do not exist and hazard follows the base equation above.

Test Plan:
- Reset: hold rst_n=0 with all req_valid=1 -> req_ready=0, we3=0, hazard=0. Release -> requester 0 is granted first.
- Round-robin: all three requesters valid continuously for 6 cycles -> grant order 0,1,2,0,1,2. we3=1 every cycle from cycle 2, with a3/wd3 following each winner's data one cycle after its grant.
- x0 drop: requester 1 sends addr=0, data=0xDEADBEEF -> req_ready[1]=1 for one cycle, we3 stays 0, and the pointer still advances to 2.
- Scoreboard: sb_set with addr=5, then check chk_a1=5 -> hazard=1. Requester 0 writes x5 = 0x12345678 -> hazard stays 1 through the clear edge and is 0 in the cycle after.
- Set/clear collision: on the edge where we3=1 and a3=7, also assert sb_set with sb_set_addr=7 -> pend[7] remains 1 and hazard=1 for chk_a2=7.
- Bypass (macro on): while we3=1, a3=9, wd3=0xA5A5A5A5, set chk_a1=9 -> byp1_hit=1, byp_data=0xA5A5A5A5, hazard=0. With the macro off, the same stimulus gives hazard=1.
